// File: rtl/relu_argmax_collector.sv
`default_nettype none
// ============================================================================
// Module   : relu_argmax_collector
// Purpose  : Collects one layer of FP32 neuron results from the processing
//            element, applies ReLU, stores them in a readable layer buffer
//            and tracks the argmax / maximum of the post-ReLU values.
// Revision : 1.0 - initial release
// ============================================================================
module relu_argmax_collector #(
    parameter int NEURONS = 10,
    parameter int IDX_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      pe_out,
    input  logic             done_flag,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             layer_done,
    output logic [IDX_W-1:0] argmax_idx,
    output logic [31:0]      max_val,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);
    localparam logic [IDX_W:0]   DEPTH    = (IDX_W + 1)'(NEURONS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      layer_buf [NEURONS];
    logic [31:0]      relu_val;
    logic             is_nan;
    logic             accept;
    logic             stray;
    logic             rd_in_range;

    // ReLU: negatives (including -0/-inf) and every NaN collapse to +0
    always_comb begin
        is_nan   = (&pe_out[30:23]) && (|pe_out[22:0]);
        relu_val = (pe_out[31] || is_nan) ? 32'h0000_0000 : pe_out;
    end

    // start always takes priority over a coincident result
    assign accept      = done_flag && !start && (state == COLLECT);
    assign stray       = done_flag && !start && (state != COLLECT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
    assign busy        = (state == COLLECT);
    assign layer_done  = (state == DONE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (start)
            next_state = COLLECT;
        else if (accept && (wr_idx == LAST_IDX))
            next_state = DONE;
    end

    // Write index, running argmax and sticky overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx     <= '0;
            argmax_idx <= '0;
            max_val    <= '0;
            overrun    <= 1'b0;
        end else if (start) begin
            wr_idx     <= '0;
            argmax_idx <= '0;
            max_val    <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                // non-negative floats order like unsigned ints; strict > keeps lowest index on ties
                if (relu_val > max_val) begin
                    argmax_idx <= wr_idx;
                    max_val    <= relu_val;
                end
            end
            if (stray)
                overrun <= 1'b1;
        end
    end

    // Layer buffer write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NEURONS; i++)
                layer_buf[i] <= '0;
        end else if (accept) begin
            layer_buf[wr_idx] <= relu_val;
        end
    end

    // Registered read port; out-of-range addresses read as zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_in_range ? layer_buf[rd_addr] : 32'h0000_0000;
        end
    end

endmodule
`default_nettype wire
